// File: rtl/enc_xor_stage.sv
`default_nettype none
// ============================================================================
//  Module      : enc_xor_stage
//  Description : Whitening stage for the tail of the encryption datapath.
//                Each accepted word is XORed with a loadable key register.
//                The result is placed in a two-entry FIFO buffer. The buffer
//                decouples the upstream and downstream valid/ready handshakes
//                and sustains one word per cycle. An accepted-word counter
//                is also provided.
//
//  Optional feature (compile-time macro):
//    ENC_XOR_STAGE_ROTKEY_EN : when defined, the key rotates left by one bit
//                              after every accepted word. A key_load in the
//                              same cycle wins, and the loaded value is kept
//                              unrotated.
//
//  Parameters
//    DATA_W   : data / key width in bits (>= 2)
//    KEY_INIT : key register value after reset
//    CNT_W    : width of the accepted-word counter
//
//  Ports
//    clk       in   1       clock, rising edge
//    rst       in   1       synchronous active-high reset
//    key_load  in   1       load key_in into the key register
//    key_in    in   DATA_W  new key value
//    valid_in  in   1       upstream word valid
//    in_data   in   DATA_W  upstream word
//    ready_out out  1       stage can accept a word (to upstream)
//    out_data  out  DATA_W  transformed word at buffer head
//    valid_out out  1       out_data valid (to downstream)
//    ready_in  in   1       downstream can accept
//    word_cnt  out  CNT_W   words accepted since reset (wrapping)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module enc_xor_stage #(
   parameter int                DATA_W   = 16,
   parameter logic [DATA_W-1:0] KEY_INIT = 16'hAAAA,
   parameter int                CNT_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_load,
   input  logic [DATA_W-1:0] key_in,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] in_data,
   output logic              ready_out,
   output logic [DATA_W-1:0] out_data,
   output logic              valid_out,
   input  logic              ready_in,
   output logic [CNT_W-1:0]  word_cnt
);

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_FULL  = 2'd2;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [DATA_W-1:0] buf_q [2];
   logic [DATA_W-1:0] buf_d [2];
   logic              head_q;
   logic              head_d;
   logic [1:0]        occ_q;
   logic [1:0]        occ_d;
   logic [DATA_W-1:0] key_q;
   logic [DATA_W-1:0] key_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;

   // ------------------------------------------------------------------------
   // Handshake decode
   // ------------------------------------------------------------------------
   logic push;
   logic pop;
   logic tail_idx;

   // ready_out depends on registered occupancy only, so there is no
   // combinational path from ready_in or valid_in to ready_out.
   assign ready_out = (occ_q != OCC_FULL);
   assign valid_out = (occ_q != OCC_EMPTY);
   assign out_data  = buf_q[head_q];
   assign word_cnt  = cnt_q;

   assign push = valid_in && ready_out;
   assign pop  = valid_out && ready_in;

   // The write slot sits directly behind the head. With occ=0 that slot is
   // the head itself. With occ=1 it is the other slot. No push happens at
   // occ=2. A push together with a pop at occ=1 writes the other slot, and
   // the head pointer advances onto it in the same edge.
   assign tail_idx = head_q ^ occ_q[0];

   // ------------------------------------------------------------------------
   // Buffer next-state
   // ------------------------------------------------------------------------
   always_comb begin
      buf_d[0] = buf_q[0];
      buf_d[1] = buf_q[1];
      if (push) begin
         // The key sampled here is the pre-edge value, so a word accepted
         // together with key_load still uses the old key.
         buf_d[tail_idx] = in_data ^ key_q;
      end
   end

   always_comb begin
      head_d = head_q;
      if (pop) begin
         head_d = ~head_q;
      end
   end

   always_comb begin
      occ_d = occ_q;
      unique case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   // ------------------------------------------------------------------------
   // Key register next-state
   // ------------------------------------------------------------------------
   logic [DATA_W-1:0] key_rot;

   assign key_rot = {key_q[DATA_W-2:0], key_q[DATA_W-1]};

`ifdef ENC_XOR_STAGE_ROTKEY_EN
   always_comb begin
      key_d = key_q;
      if (key_load) begin
         key_d = key_in;
      end else if (push) begin
         key_d = key_rot;
      end
   end
`else
   // Rotation is unused in this build. Keep the net referenced so the
   // datapath structure stays identical between the two builds.
   logic key_rot_unused;
   assign key_rot_unused = ^key_rot;

   always_comb begin
      key_d = key_q;
      if (key_load) begin
         key_d = key_in;
      end
   end
`endif

   // ------------------------------------------------------------------------
   // Accepted-word counter; wraps naturally at 2^CNT_W
   // ------------------------------------------------------------------------
   always_comb begin
      cnt_d = cnt_q;
      if (push) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   // The buffer storage is cleared on reset. After reset, out_data then reads
   // zero until the first word arrives, and head_q returns to slot 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_q[0] <= '0;
         buf_q[1] <= '0;
         head_q   <= 1'b0;
         occ_q    <= OCC_EMPTY;
         key_q    <= KEY_INIT;
         cnt_q    <= '0;
      end else begin
         buf_q[0] <= buf_d[0];
         buf_q[1] <= buf_d[1];
         head_q   <= head_d;
         occ_q    <= occ_d;
         key_q    <= key_d;
         cnt_q    <= cnt_d;
      end
   end

   // OCC_ONE names the single-entry state for readers. The decode above
   // only needs occ_q[0] to locate the write slot.
   logic occ_one_unused;
   assign occ_one_unused = (occ_q == OCC_ONE);

endmodule
`default_nettype wire

// File: tb/tb_enc_xor_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enc_xor_stage
//  Description : Self-checking bench for enc_xor_stage. Directed scenarios
//                are followed by random traffic. All outputs are compared
//                against a queue-based reference model. A second instance
//                with CNT_W=2 exercises counter wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_enc_xor_stage;

   localparam int          DATA_W   = 16;
   localparam logic [15:0] KEY_INIT = 16'hAAAA;

   logic        clk = 1'b0;
   logic        rst;
   logic        key_load;
   logic [15:0] key_in;
   logic        valid_in;
   logic [15:0] in_data;
   logic        ready_in;

   logic        ready_out;
   logic [15:0] out_data;
   logic        valid_out;
   logic [7:0]  word_cnt;

   logic        ready_out2;
   logic [15:0] out_data2;
   logic        valid_out2;
   logic [1:0]  word_cnt2;

   always #5 clk = ~clk;

   enc_xor_stage #(.DATA_W(DATA_W), .KEY_INIT(KEY_INIT), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
      .valid_in(valid_in), .in_data(in_data), .ready_out(ready_out),
      .out_data(out_data), .valid_out(valid_out), .ready_in(ready_in),
      .word_cnt(word_cnt)
   );

   enc_xor_stage #(.DATA_W(DATA_W), .KEY_INIT(KEY_INIT), .CNT_W(2)) u_dut_c2 (
      .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
      .valid_in(valid_in), .in_data(in_data), .ready_out(ready_out2),
      .out_data(out_data2), .valid_out(valid_out2), .ready_in(ready_in),
      .word_cnt(word_cnt2)
   );

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   logic [15:0] m_q[$];
   logic [15:0] m_key;
   int          m_cnt;
   bit          m_fresh;   // no word accepted since reset: out_data reads 0

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge(input logic r, input logic kl, input logic [15:0] kin,
                             input logic v, input logic [15:0] d, input logic rdy);
      bit do_push;
      bit do_pop;
      if (r) begin
         m_q.delete();
         m_key   = KEY_INIT;
         m_cnt   = 0;
         m_fresh = 1'b1;
      end else begin
         do_push = v && (m_q.size() < 2);
         do_pop  = rdy && (m_q.size() > 0);
         if (do_pop) void'(m_q.pop_front());
         if (do_push) begin
            m_q.push_back(d ^ m_key);
            m_cnt   = (m_cnt + 1) % 256;
            m_fresh = 1'b0;
         end
         if (kl) m_key = kin;
`ifdef ENC_XOR_STAGE_ROTKEY_EN
         else if (do_push) m_key = {m_key[14:0], m_key[15]};
`endif
      end
   endtask

   task automatic compare_all();
      check("ready_out", 32'(ready_out), 32'(m_q.size() < 2));
      check("valid_out", 32'(valid_out), 32'(m_q.size() != 0));
      if (m_q.size() != 0) check("out_data", 32'(out_data), 32'(m_q[0]));
      else if (m_fresh)    check("out_data_rst", 32'(out_data), 32'h0);
      check("word_cnt", 32'(word_cnt), 32'(m_cnt));
      check("word_cnt_w2", 32'(word_cnt2), 32'(m_cnt % 4));
   endtask

   // Drive one cycle of inputs, advance one edge, update model, compare.
   task automatic step(input logic r, input logic kl, input logic [15:0] kin,
                       input logic v, input logic [15:0] d, input logic rdy);
      rst = r; key_load = kl; key_in = kin; valid_in = v; in_data = d; ready_in = rdy;
      @(posedge clk);
      model_edge(r, kl, kin, v, d, rdy);
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; key_load = 1'b0; key_in = '0; valid_in = 1'b0; in_data = '0; ready_in = 1'b0;
      m_key = KEY_INIT; m_cnt = 0; m_fresh = 1'b1;

      // Reset state
      do_reset();
      do_reset();
      check("rst_valid_out", 32'(valid_out), 32'h0);
      check("rst_ready_out", 32'(ready_out), 32'h1);
      check("rst_out_data", 32'(out_data), 32'h0);
      check("rst_word_cnt", 32'(word_cnt), 32'h0);

      // Single word, one-cycle latency
      step(1'b0, 1'b0, 16'h0, 1'b1, 16'h1234, 1'b1);
      check("lat_out", 32'(out_data), 32'hB89E);
      check("lat_valid", 32'(valid_out), 32'h1);
      check("lat_cnt", 32'(word_cnt), 32'h1);
      step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

      // Stall: two absorbed, third refused
      do_reset();
      step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0001, 1'b0);
      check("stall_rdy1", 32'(ready_out), 32'h1);
      step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0002, 1'b0);
      check("stall_rdy2", 32'(ready_out), 32'h0);
      step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0003, 1'b0);
      check("stall_cnt", 32'(word_cnt), 32'h2);
`ifndef ENC_XOR_STAGE_ROTKEY_EN
      check("stall_head", 32'(out_data), 32'hAAAB);
`endif
      step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
      check("stall_ready_back", 32'(ready_out), 32'h1);
`ifndef ENC_XOR_STAGE_ROTKEY_EN
      check("stall_second", 32'(out_data), 32'hAAA8);
`endif
      step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

      // key_load coincident with a push uses the old key
      do_reset();
      step(1'b0, 1'b1, 16'h00FF, 1'b1, 16'h0000, 1'b1);
      check("kl_old_key", 32'(out_data), 32'hAAAA);
      step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, 1'b1);
      check("kl_new_key", 32'(out_data), 32'h00FF);
      step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);

`ifdef ENC_XOR_STAGE_ROTKEY_EN
      // Rotating key, back-to-back pushes
      do_reset();
      step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, 1'b1);
      check("rot_w0", 32'(out_data), 32'hAAAA);
      step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, 1'b1);
      check("rot_w1", 32'(out_data), 32'h5555);
      step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, 1'b1);
      check("rot_w2", 32'(out_data), 32'hAAAA);
      step(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
`endif

      // Narrow counter wrap: 1,2,3,0,1
      do_reset();
      for (int i = 0; i < 5; i++) begin
         logic [1:0] exp_c;
         exp_c = 2'(i + 1);
         step(1'b0, 1'b0, 16'h0, 1'b1, 16'(i), 1'b1);
         check("cnt2_seq", 32'(word_cnt2), 32'(exp_c));
      end

      // Reset while full
      do_reset();
      step(1'b0, 1'b1, 16'h1357, 1'b1, 16'h1111, 1'b0);
      step(1'b0, 1'b0, 16'h0, 1'b1, 16'h2222, 1'b0);
      check("full_before_rst", 32'(ready_out), 32'h0);
      do_reset();
      check("midrst_valid", 32'(valid_out), 32'h0);
      check("midrst_ready", 32'(ready_out), 32'h1);
      check("midrst_cnt", 32'(word_cnt), 32'h0);
      step(1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, 1'b1);
      check("midrst_key", 32'(out_data), 32'hAAAA);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         logic r, kl, v, rdy;
         logic [15:0] kin, d;
         r   = ($urandom_range(0, 299) == 0);
         kl  = ($urandom_range(0, 11) == 0);
         kin = 16'($urandom);
         v   = ($urandom_range(0, 3) != 0);
         d   = 16'($urandom);
         rdy = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         step(r, kl, kin, v, d, rdy);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
